// File: rtl/memory_stage.sv
// Memory stage of the five-stage RISC-V pipeline: valid/ready data-memory access,
// load alignment/extension, stall generation and the M/W pipeline register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no access outstanding; MemReq follows the current instruction
// ST_WAIT | request issued but not yet accepted; MemReq held, pipeline stalled
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic        Stall,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic        is_load;
    logic        access;
    logic        size_byte;
    logic        size_half;
    logic        size_word;
    logic        misalign;
    logic        aligned_access;
    logic [1:0]  byte_off;
    logic [4:0]  bit_off;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    assign is_load   = (ResultSrcM == 2'b01);
    assign access    = MemWriteM | is_load;
    assign byte_off  = ALUResultM[1:0];
    assign bit_off   = {byte_off, 3'b000};

    // Funct3M[1] set means word; unused encodings fall into the word path.
    assign size_byte = (Funct3M[1:0] == 2'b00);
    assign size_half = (Funct3M[1:0] == 2'b01);
    assign size_word = Funct3M[1];

    assign misalign = access & ((size_half & byte_off[0]) |
                                (size_word & (byte_off != 2'b00)));
    assign aligned_access = access & ~misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        MemReq    = 1'b0;
        case (state)
            ST_IDLE: begin
                MemReq = aligned_access;
                if (aligned_access && !MemReady) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Stall    = MemReq & ~MemReady;
    assign MemWe    = MemReq & MemWriteM;
    assign MemAddr  = {ALUResultM[31:2], 2'b00};
    assign MemWData = WriteDataM << bit_off;

    always_comb begin
        MemByteEn = 4'b1111;
        if (size_byte) begin
            MemByteEn = 4'b0001 << byte_off;
        end else if (size_half) begin
            MemByteEn = 4'b0011 << {byte_off[1], 1'b0};
        end
    end

    assign rdata_shifted = MemRData >> bit_off;

    always_comb begin
        load_ext = MemRData;
        case (Funct3M)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {24'h000000, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'h0000, rdata_shifted[15:0]};
            default: load_ext = MemRData;
        endcase
    end

    // A stalled cycle retires a bubble; the completing cycle (Stall low) captures.
    always_ff @(posedge clk) begin
        if (rst || Stall) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            RdW        <= 5'd0;
            PCPlus4W   <= 32'h0;
            MisalignW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~misalign;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (is_load && !misalign) ? load_ext : 32'h0;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            MisalignW  <= misalign;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by random instruction
// streams, each checked against an arithmetic model of the memory stage.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemByteEn;
    logic        MemReady;
    logic [31:0] MemRData;
    logic        Stall;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic        MisalignW;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rdata;
    } instr_t;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemByteEn  (MemByteEn),
        .MemReady   (MemReady),
        .MemRData   (MemRData),
        .Stall      (Stall),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .PCPlus4W   (PCPlus4W),
        .MisalignW  (MisalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model: plain arithmetic on access size and address ----
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % access_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = access_bytes(f3);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        longint v;
        int     bits;
        bits = 8 * access_bytes(f3);
        if (bits == 32) return word;
        v = (longint'(word) >> (8 * (addr % 4))) % (longint'(1) << bits);
        if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    task automatic check_w(input string tag, input logic rw, input logic [1:0] rs,
                           input logic [31:0] alu, input logic [31:0] rdat,
                           input logic [4:0] rd, input logic [31:0] pc, input logic mis);
        check({tag, ".RegWriteW"},  {31'b0, RegWriteW}, {31'b0, rw});
        check({tag, ".ResultSrcW"}, {30'b0, ResultSrcW}, {30'b0, rs});
        check({tag, ".ALUResultW"}, ALUResultW, alu);
        check({tag, ".ReadDataW"},  ReadDataW, rdat);
        check({tag, ".RdW"},        {27'b0, RdW}, {27'b0, rd});
        check({tag, ".PCPlus4W"},   PCPlus4W, pc);
        check({tag, ".MisalignW"},  {31'b0, MisalignW}, {31'b0, mis});
    endtask

    task automatic drive(input instr_t in);
        RegWriteM  = in.rw;
        ResultSrcM = in.rs;
        MemWriteM  = in.mw;
        Funct3M    = in.f3;
        ALUResultM = in.alu;
        WriteDataM = in.wd;
        RdM        = in.rd;
        PCPlus4M   = in.pc;
    endtask

    // Presents one instruction; memory answers after 'waits' not-ready cycles.
    task automatic run(input string tag, input instr_t in, input int waits);
        bit          is_load, acc, mis, req, stall_e;
        int          nw;
        logic [31:0] exp_rd;
        is_load = (in.rs == 2'b01);
        acc     = in.mw || is_load;
        mis     = acc && model_misaligned(in.f3, in.alu);
        req     = acc && !mis;
        nw      = req ? waits : 0;
        for (int c = 0; c <= nw; c++) begin
            @(negedge clk);
            drive(in);
            MemReady = req ? (c == nw) : 1'($urandom_range(0, 1));
            MemRData = (req && c == nw) ? in.rdata : $urandom;
            #1;
            stall_e = req && (c != nw);
            check({tag, ".MemReq"}, {31'b0, MemReq}, {31'b0, req});
            check({tag, ".Stall"},  {31'b0, Stall},  {31'b0, stall_e});
            if (req) begin
                check({tag, ".MemWe"},     {31'b0, MemWe}, {31'b0, in.mw});
                check({tag, ".MemAddr"},   MemAddr, in.alu - (in.alu % 4));
                check({tag, ".MemByteEn"}, {28'b0, MemByteEn}, {28'b0, model_be(in.f3, in.alu)});
                if (in.mw) check({tag, ".MemWData"}, MemWData, in.wd * (32'd1 << (8 * (in.alu % 4))));
            end
            exp_rd = (is_load && !mis) ? model_load(in.f3, in.alu, in.rdata) : 32'h0;
            @(posedge clk);
            #1;
            if (stall_e) begin
                check_w({tag, ".bubble"}, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
            end else begin
                check_w(tag, in.rw && !mis, in.rs, in.alu, exp_rd, in.rd, in.pc, mis);
            end
        end
    endtask

    function automatic instr_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                  input logic [2:0] f3, input logic [31:0] alu,
                                  input logic [31:0] wd, input logic [31:0] rdata);
        instr_t i;
        i.rw = rw; i.rs = rs; i.mw = mw; i.f3 = f3; i.alu = alu; i.wd = wd;
        i.rd = 5'(alu[4:0] ^ 5'd7); i.pc = alu ^ 32'h1000_0004; i.rdata = rdata;
        return i;
    endfunction

    task automatic gen(output instr_t i);
        int          kind;
        logic [2:0]  load_f3 [5];
        logic [2:0]  store_f3[3];
        load_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_f3 = '{3'b000, 3'b001, 3'b010};
        kind = $urandom_range(0, 9);
        i = mk(1'b1, 2'b00, 1'b0, 3'($urandom), $urandom, $urandom, $urandom);
        i.rd = 5'($urandom);
        i.pc = $urandom;
        if (kind == 1) begin
            i.rs = 2'b10;
        end else if (kind >= 2 && kind <= 6) begin
            i.rs = 2'b01;
            i.f3 = load_f3[kind - 2];
        end else if (kind >= 7) begin
            i.rw = 1'b0;
            i.mw = 1'b1;
            i.f3 = store_f3[kind - 7];
        end
        if (kind >= 2 && $urandom_range(0, 3) != 0) begin
            if (i.f3[1]) i.alu[1:0] = 2'b00;
            else if (i.f3[0]) i.alu[0] = 1'b0;
        end
    endtask

    instr_t nop;
    instr_t ins;

    initial begin
        rst = 1'b1;
        nop = mk(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        nop.rd = 5'd0;
        nop.pc = 32'h0;
        drive(nop);
        MemReady = 1'b0;
        MemRData = 32'h0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.MemReq", {31'b0, MemReq}, 32'h0);
        check("reset.Stall",  {31'b0, Stall},  32'h0);
        check_w("reset", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // directed scenarios
        run("lw_zero_wait", mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF), 0);
        run("lb_sext_3wait", mk(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000), 3);
        run("sh", mk(1'b0, 2'b00, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0), 1);
        run("lw_misaligned", mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678), 2);
        run("add", mk(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0), 0);
        run("lhu", mk(1'b1, 2'b01, 1'b0, 3'b101, 32'h6, 32'h0, 32'h8001_0000), 0);
        run("lw_b2b", mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D), 2);

        // reset during the second wait cycle
        ins = mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 32'h55AA55AA);
        @(negedge clk);
        drive(ins);
        MemReady = 1'b0;
        #1;
        check("rstwait.c1.Stall", {31'b0, Stall}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwait.c2.MemReq", {31'b0, MemReq}, 32'h1);
        @(posedge clk);
        #1;
        check_w("rstwait.after", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        rst = 1'b0;
        run("rstwait.idle", nop, 0);

        // random instruction stream
        for (int k = 0; k < 300; k++) begin
            gen(ins);
            run("rand", ins, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
